// File: rtl/lcd_timing_pkg.sv
// Shared timing defaults, per-pixel scan flags and counter sizing helpers
// for the LCD scan engine.
package lcd_timing_pkg;

   localparam int unsigned DEF_ADR_WIDTH = 10;
   localparam int unsigned DEF_DAT_WIDTH = 24;
   localparam int unsigned DEF_CLK_DIV   = 4;
   localparam int unsigned DEF_H_ACTIVE  = 32;
   localparam int unsigned DEF_H_FP      = 2;
   localparam int unsigned DEF_H_SYNC    = 4;
   localparam int unsigned DEF_H_BP      = 2;
   localparam int unsigned DEF_V_ACTIVE  = 32;
   localparam int unsigned DEF_V_FP      = 1;
   localparam int unsigned DEF_V_SYNC    = 2;
   localparam int unsigned DEF_V_BP      = 1;

   typedef struct packed {
      logic active;
      logic hsync;
      logic vsync;
      logic first;
   } scan_flags_t;

   function automatic int unsigned calc_total(input int unsigned act,
                                              input int unsigned fp,
                                              input int unsigned sync,
                                              input int unsigned bp);
      return act + fp + sync + bp;
   endfunction

   // Wide enough to hold 0..total inclusive, so sync-end compares never overflow.
   function automatic int unsigned cnt_width(input int unsigned total);
      return (total < 1) ? 1 : $clog2(total + 1);
   endfunction

endpackage

// File: rtl/lcd_timing_counter.sv
// Pixel divider plus horizontal/vertical scan counters; flags describe the
// pixel currently held by the counters.
module lcd_timing_counter
   import lcd_timing_pkg::*;
#(
   parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP
)(
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        enable_i,
   output logic        pix_start_o,
   output scan_flags_t flags_o
);

   localparam int unsigned H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int unsigned V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int unsigned DW = cnt_width(CLK_DIV);
   localparam int unsigned HW = cnt_width(H_TOTAL);
   localparam int unsigned VW = cnt_width(V_TOTAL);

   localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
   localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_START   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_START   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);

   logic [DW-1:0] div_q, div_d;
   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;
   logic          pix_ce;

   always_comb begin
      pix_ce = (div_q == DIV_LAST);
      div_d  = pix_ce ? '0 : div_q + 1'b1;
      h_d    = h_q;
      v_d    = v_q;
      if (pix_ce) begin
         if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
         end else begin
            h_d = h_q + 1'b1;
         end
      end
   end

   // Disabled scan parks all counters at the frame origin.
   always_ff @(posedge clk_i) begin
      if (reset_i || !enable_i) begin
         div_q <= '0;
         h_q   <= '0;
         v_q   <= '0;
      end else begin
         div_q <= div_d;
         h_q   <= h_d;
         v_q   <= v_d;
      end
   end

   // The first divider phase of each pixel is when its RAM read is issued.
   assign pix_start_o = enable_i && (div_q == '0);

   always_comb begin
      flags_o.active = (h_q < H_ACT_END) && (v_q < V_ACT_END);
      flags_o.hsync  = (h_q >= HS_START) && (h_q < HS_END);
      flags_o.vsync  = (v_q >= VS_START) && (v_q < VS_END);
      flags_o.first  = (h_q == '0) && (v_q == '0);
   end

endmodule

// File: rtl/lcd_scan_ctrl.sv
// Frame-buffer scan engine: issues RAM reads per active pixel and drives the
// panel pixel clock, syncs, data enable and RGB two pipeline stages later.
module lcd_scan_ctrl
   import lcd_timing_pkg::*;
#(
   parameter int unsigned ADR_WIDTH = DEF_ADR_WIDTH,
   parameter int unsigned DAT_WIDTH = DEF_DAT_WIDTH,
   parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
   parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
   parameter int unsigned H_FP      = DEF_H_FP,
   parameter int unsigned H_SYNC    = DEF_H_SYNC,
   parameter int unsigned H_BP      = DEF_H_BP,
   parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
   parameter int unsigned V_FP      = DEF_V_FP,
   parameter int unsigned V_SYNC    = DEF_V_SYNC,
   parameter int unsigned V_BP      = DEF_V_BP
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   output logic                 ram_en,
   output logic [ADR_WIDTH-1:0] ram_adr,
   input  logic [DAT_WIDTH-1:0] ram_dat,
   output logic                 lcd_pclk,
   output logic                 lcd_hsync_n,
   output logic                 lcd_vsync_n,
   output logic                 lcd_de,
   output logic [DAT_WIDTH-1:0] lcd_rgb,
   output logic                 frame_start
);

   localparam int unsigned    PW       = cnt_width(CLK_DIV / 2);
   localparam logic [PW-1:0]  PCLK_LOW = PW'(CLK_DIV / 2);

   logic        pix_start;
   scan_flags_t flags;

   lcd_timing_counter #(
      .CLK_DIV  (CLK_DIV),
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP)
   ) u_timing (
      .clk_i       (clk),
      .reset_i     (reset),
      .enable_i    (enable),
      .pix_start_o (pix_start),
      .flags_o     (flags)
   );

   logic [ADR_WIDTH-1:0] adr_cnt_q, adr_cnt_d, adr_issue;
   logic [ADR_WIDTH-1:0] ram_adr_q, ram_adr_d;
   logic                 ram_en_q, ram_en_d;
   scan_flags_t          flags1_q, flags2_q;
   logic                 vld1_q, vld2_q;
   logic [DAT_WIDTH-1:0] rgb_q, rgb_d;
   logic                 de_q, de_d;
   logic                 hs_n_q, hs_n_d;
   logic                 vs_n_q, vs_n_d;
   logic                 fs_q, fs_d;
   logic                 pclk_q, pclk_d;
   logic [PW-1:0]        pclk_cnt_q, pclk_cnt_d;

   // The frame origin forces address 0 so a wrapped or aborted frame realigns.
   always_comb begin
      adr_issue = flags.first ? '0 : adr_cnt_q;
      adr_cnt_d = adr_cnt_q;
      ram_adr_d = ram_adr_q;
      ram_en_d  = 1'b0;
      if (pix_start) begin
         ram_adr_d = adr_issue;
         ram_en_d  = flags.active;
         adr_cnt_d = flags.active ? adr_issue + 1'b1 : adr_issue;
      end
   end

   // pclk_cnt of zero means idle; it runs only during the low half of pclk.
   always_comb begin
      rgb_d      = rgb_q;
      de_d       = de_q;
      hs_n_d     = hs_n_q;
      vs_n_d     = vs_n_q;
      fs_d       = 1'b0;
      pclk_d     = pclk_q;
      pclk_cnt_d = pclk_cnt_q;
      if (vld2_q) begin
         rgb_d      = flags2_q.active ? ram_dat : '0;
         de_d       = flags2_q.active;
         hs_n_d     = !flags2_q.hsync;
         vs_n_d     = !flags2_q.vsync;
         fs_d       = flags2_q.first;
         pclk_d     = 1'b0;
         pclk_cnt_d = PW'(1);
      end else if (pclk_cnt_q != '0) begin
         if (pclk_cnt_q == PCLK_LOW) begin
            pclk_d     = 1'b1;
            pclk_cnt_d = '0;
         end else begin
            pclk_cnt_d = pclk_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset || !enable) begin
         adr_cnt_q  <= '0;
         ram_adr_q  <= '0;
         ram_en_q   <= 1'b0;
         flags1_q   <= '0;
         flags2_q   <= '0;
         vld1_q     <= 1'b0;
         vld2_q     <= 1'b0;
         rgb_q      <= '0;
         de_q       <= 1'b0;
         hs_n_q     <= 1'b1;
         vs_n_q     <= 1'b1;
         fs_q       <= 1'b0;
         pclk_q     <= 1'b0;
         pclk_cnt_q <= '0;
      end else begin
         adr_cnt_q  <= adr_cnt_d;
         ram_adr_q  <= ram_adr_d;
         ram_en_q   <= ram_en_d;
         flags1_q   <= flags;
         flags2_q   <= flags1_q;
         vld1_q     <= pix_start;
         vld2_q     <= vld1_q;
         rgb_q      <= rgb_d;
         de_q       <= de_d;
         hs_n_q     <= hs_n_d;
         vs_n_q     <= vs_n_d;
         fs_q       <= fs_d;
         pclk_q     <= pclk_d;
         pclk_cnt_q <= pclk_cnt_d;
      end
   end

   assign ram_en      = ram_en_q;
   assign ram_adr     = ram_adr_q;
   assign lcd_pclk    = pclk_q;
   assign lcd_hsync_n = hs_n_q;
   assign lcd_vsync_n = vs_n_q;
   assign lcd_de      = de_q;
   assign lcd_rgb     = rgb_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_lcd_scan_ctrl.sv
// Scoreboard bench for lcd_scan_ctrl: a small 8x6 timing with 4x3 active area,
// plus a 3-bit-address instance that must wrap its reads.
module tb_lcd_scan_ctrl;

   localparam int AW  = 10;
   localparam int AWW = 3;
   localparam int DW  = 24;
   localparam int HT  = 8;
   localparam int VT  = 6;

   logic clk = 1'b0;
   logic reset, enable;

   logic          ram_en, lcd_pclk, lcd_hsync_n, lcd_vsync_n, lcd_de, frame_start;
   logic [AW-1:0] ram_adr;
   logic [DW-1:0] ram_dat, lcd_rgb;

   logic           w_ram_en, w_pclk, w_hs_n, w_vs_n, w_de, w_fs;
   logic [AWW-1:0] w_ram_adr;
   logic [DW-1:0]  w_ram_dat, w_rgb;

   always #5 clk = ~clk;

   lcd_scan_ctrl #(
      .ADR_WIDTH(AW), .DAT_WIDTH(DW), .CLK_DIV(2),
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .ram_en(ram_en), .ram_adr(ram_adr), .ram_dat(ram_dat),
      .lcd_pclk(lcd_pclk), .lcd_hsync_n(lcd_hsync_n), .lcd_vsync_n(lcd_vsync_n),
      .lcd_de(lcd_de), .lcd_rgb(lcd_rgb), .frame_start(frame_start)
   );

   lcd_scan_ctrl #(
      .ADR_WIDTH(AWW), .DAT_WIDTH(DW), .CLK_DIV(2),
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
   ) dut_wrap (
      .clk(clk), .reset(reset), .enable(enable),
      .ram_en(w_ram_en), .ram_adr(w_ram_adr), .ram_dat(w_ram_dat),
      .lcd_pclk(w_pclk), .lcd_hsync_n(w_hs_n), .lcd_vsync_n(w_vs_n),
      .lcd_de(w_de), .lcd_rgb(w_rgb), .frame_start(w_fs)
   );

   // Frame RAM models preloaded with value = address, one cycle read latency.
   always @(posedge clk) begin
      if (ram_en)   ram_dat   <= DW'(ram_adr);
      if (w_ram_en) w_ram_dat <= DW'(w_ram_adr);
   end

   typedef struct packed {
      logic          de;
      logic          hs_n;
      logic          vs_n;
      logic          fs;
      logic [DW-1:0] rgb;
   } pix_t;

   typedef struct {
      int            due;
      logic [AW-1:0] a;
   } lat_t;

   pix_t           pix_q[$];
   logic [AW-1:0]  adr_q[$];
   logic [AWW-1:0] wadr_q[$];
   lat_t           lat_q[$];

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;
   int px_cnt = 0;
   int en_cnt = 0;
   int wen_cnt = 0;
   bit chk_on = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic checkBlank(input string name);
      checkOutput(name,
                  {w_ram_en, ram_en, lcd_pclk, lcd_hsync_n, lcd_vsync_n, lcd_de, frame_start, lcd_rgb},
                  {7'b0001100, 24'h0});
   endtask

   // Expected scan order: hsync low at h=5,6; vsync low on line 4; 4x3 active.
   task automatic pushFrames(input int n);
      int a;
      for (int f = 0; f < n; f++) begin
         a = 0;
         for (int v = 0; v < VT; v++) begin
            for (int h = 0; h < HT; h++) begin
               pix_t p;
               p.de   = (h < 4) && (v < 3);
               p.hs_n = !((h == 5) || (h == 6));
               p.vs_n = !(v == 4);
               p.fs   = (h == 0) && (v == 0);
               p.rgb  = p.de ? DW'(a) : '0;
               pix_q.push_back(p);
               if (p.de) begin
                  adr_q.push_back(AW'(a));
                  wadr_q.push_back(AWW'(a % 8));
                  a++;
               end
            end
         end
      end
   endtask

   task automatic flushAndArm();
      pix_q.delete();
      adr_q.delete();
      wadr_q.delete();
      pushFrames(2);
      chk_on = 1'b1;
   endtask

   task automatic applyStimulus(input logic rst, input logic en, input int cycles);
      @(posedge clk);
      #1;
      reset  = rst;
      enable = en;
      repeat (cycles) @(posedge clk);
      #2;
   endtask

   task automatic gapCheck(input string name);
      repeat (10) begin
         @(posedge clk);
         #2;
         checkBlank(name);
      end
   endtask

   // Monitor: pixels are judged when the panel would sample them (pclk rise).
   logic prev_pclk = 1'b0;
   bit   fs_seen   = 1'b0;
   int   fs_last   = -1;
   int   rise_last = -1;

   always @(negedge clk) begin
      if (!chk_on) begin
         fs_seen   = 1'b0;
         fs_last   = -1;
         rise_last = -1;
         lat_q.delete();
      end else begin
         if (lat_q.size() > 0 && lat_q[0].due == cyc) begin
            lat_t l;
            l = lat_q.pop_front();
            checkOutput("rgb_latency", {lcd_de, lcd_rgb}, {1'b1, DW'(l.a)});
         end
         if (ram_en) begin
            lat_t l;
            en_cnt++;
            if (adr_q.size() == 0) checkOutput("adr_unexpected", {1'b1, ram_adr}, 0);
            else checkOutput("ram_adr", ram_adr, adr_q.pop_front());
            l.due = cyc + 2;
            l.a   = ram_adr;
            lat_q.push_back(l);
         end
         if (w_ram_en) begin
            wen_cnt++;
            if (wadr_q.size() == 0) checkOutput("wrap_adr_unexpected", {1'b1, w_ram_adr}, 0);
            else checkOutput("wrap_ram_adr", w_ram_adr, wadr_q.pop_front());
         end
         if (frame_start) begin
            fs_seen = 1'b1;
            if (fs_last >= 0) checkOutput("frame_start_period", cyc - fs_last, 96);
            fs_last = cyc;
         end
         if (lcd_pclk && !prev_pclk) begin
            if (rise_last >= 0) checkOutput("pclk_period", cyc - rise_last, 2);
            rise_last = cyc;
            if (pix_q.size() == 0) checkOutput("pix_unexpected", 1, 0);
            else checkOutput("pixel", {lcd_de, lcd_hsync_n, lcd_vsync_n, fs_seen, lcd_rgb},
                             pix_q.pop_front());
            px_cnt++;
            fs_seen = 1'b0;
         end
      end
      prev_pclk = lcd_pclk;
   end

   int px0, en0, wen0;

   initial begin
      reset  = 1'b1;
      enable = 1'b1;
      $display("[TB] reset hold with enable high");
      repeat (5) begin
         @(posedge clk);
         #2;
         checkBlank("reset_hold");
      end

      $display("[TB] free-running scan");
      pushFrames(3);
      chk_on = 1'b1;
      px0  = px_cnt;
      en0  = en_cnt;
      wen0 = wen_cnt;
      applyStimulus(1'b0, 1'b1, 96);
      checkOutput("ram_en_per_frame", en_cnt - en0, 12);
      checkOutput("wrap_ram_en_per_frame", wen_cnt - wen0, 12);
      applyStimulus(1'b0, 1'b1, 116);
      checkOutput("pix_progress_run", (px_cnt - px0) >= 96, 1);

      $display("[TB] enable dropped mid-line 1");
      chk_on = 1'b0;
      enable = 1'b0;
      gapCheck("enable_gap");
      flushAndArm();
      enable = 1'b1;
      px0 = px_cnt;
      repeat (116) @(posedge clk);
      #2;
      checkOutput("pix_progress_enable", (px_cnt - px0) >= 48, 1);

      $display("[TB] reset pulsed mid-line 1");
      chk_on = 1'b0;
      reset  = 1'b1;
      gapCheck("reset_gap");
      flushAndArm();
      reset = 1'b0;
      px0 = px_cnt;
      repeat (120) @(posedge clk);
      #2;
      checkOutput("pix_progress_reset", (px_cnt - px0) >= 48, 1);

      chk_on = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
